bus_master: RTL
===============

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of ACCESS-state cycles allowed without ready before the transfer aborts.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  1  user request strobe; sampled only in IDLE.
REQ-005 req_mode  input  1  1=write, 0=read.
REQ-006 req_addr  input  16  target address.
REQ-007 req_wdata  input  8  write data.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  valid only with done; 1 = decode miss or timeout.
REQ-011 rd_data  output  8  last successfully read byte.
REQ-012 mode, addr[15:0], wdata[7:0], valid  output  bus request to slaves.
REQ-013 s1, s2, s3  output  1 each  one-hot slave selects.
REQ-014 rdata  input  8  slave read data; ready  input  1  slave completion.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, ACCESS, DONE.
REQ-016 IDLE with req=1: latch req_mode/req_addr/req_wdata; go to ADDR if decode hits, else go to DONE with err flagged.
REQ-017 Decode on addr[15:12]: 0x0->s1, 0x1->s2, 0x2->s3; any other value is a miss; at most one select high at any time.
REQ-018 ADDR (exactly 1 cycle): mode/addr/wdata driven from latches, decoded select high, valid=0; next state ACCESS.
REQ-019 ACCESS: select and valid high, bus outputs stable; stays until ready=1, then DONE.
REQ-020 Timeout counter clears on ACCESS entry and increments each ACCESS cycle with ready=0; reaching TIMEOUT goes to DONE with err=1.
REQ-021 ready and TIMEOUT reached in the same cycle: ready wins, err=0.
REQ-022 Read completion (mode=0, ready=1 in ACCESS): rd_data captures rdata on that edge; writes, errors and timeouts leave rd_data unchanged.
REQ-023 DONE (1 cycle): done=1, err per outcome, valid and all selects low; next state IDLE.
REQ-024 Minimum latency: req at cycle N, ready high on first ACCESS cycle -> done at cycle N+3; decode miss -> done at N+1.
REQ-025 req asserted while busy is ignored, not queued; ready outside ACCESS is ignored.
REQ-026 In IDLE: valid=0, selects=0, mode/addr/wdata hold last driven values.

Reset
REQ-027 rst=1 at a clock edge forces IDLE regardless of state, including mid-ACCESS.
REQ-028 Reset values: busy=0, done=0, err=0, valid=0, s1=s2=s3=0, mode=0, addr=0x0000, wdata=0x00, rd_data=0x00, timeout counter=0.
REQ-029 An aborted transfer SHALL NOT produce done.

Structure
REQ-030 Shared package bus_pkg holds the state enum, MODE_READ=0/MODE_WRITE=1 constants, and slave region constants (0x0, 0x1, 0x2 on addr[15:12]).
REQ-031 Decode logic is a combinational sub-module addr_decoder (addr in, s1/s2/s3/miss out), reusable by other bus masters.

Verification
REQ-032 Write: req=1, req_mode=1, req_addr=0x0001, req_wdata=0xFF; ready on 2nd ACCESS cycle -> s1=1, mode=1, addr=0x0001, wdata=0xFF, valid=1 in ACCESS; done=1, err=0; rd_data unchanged.
REQ-033 Read: req_mode=0, req_addr=0x1004, rdata=0xA5 with ready on 1st ACCESS cycle -> s2 only select, done at N+3, err=0, rd_data=0xA5.
REQ-034 Decode miss: req_addr=0x7000 -> no select or valid ever high, done=1, err=1 at N+1.
REQ-035 Timeout: req_addr=0x2000, ready held 0 -> valid high exactly 16 cycles, then done=1, err=1, rd_data unchanged.
REQ-036 Reset mid-ACCESS: rst=1 on 3rd ACCESS cycle -> next edge valid=0, selects=0, busy=0, no done pulse; new req then completes normally.
REQ-037 req held high through a completed transfer -> a new transfer starts from IDLE only after the done cycle, never mid-transfer.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM states, transfer modes and slave address regions for bus masters.
package bus_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic [3:0] REGION_S1 = 4'h0;
    localparam logic [3:0] REGION_S2 = 4'h1;
    localparam logic [3:0] REGION_S3 = 4'h2;

endpackage

// File: rtl/addr_decoder.sv
// addr_decoder: one-hot slave select from the top address nibble, with a miss flag.
module addr_decoder
    import bus_pkg::*;
(
    input  logic [3:0] addr_hi,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       miss
);

    assign s1   = addr_hi == REGION_S1;
    assign s2   = addr_hi == REGION_S2;
    assign s3   = addr_hi == REGION_S3;
    assign miss = !(s1 || s2 || s3);

endmodule

// File: rtl/bus_master.sv
// bus_master: single-outstanding bus master with address decode, access timeout and read capture.
module bus_master
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_mode,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic        mode,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        valid,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    input  logic [7:0]  rdata,
    input  logic        ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rd_q, rd_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      dec_hi;
    logic            d1, d2, d3, miss, sel_en;

    // In IDLE the decoder judges the incoming request; otherwise it drives the latched target.
    assign dec_hi = state_q == IDLE ? req_addr[15:12] : addr_q[15:12];

    addr_decoder u_dec (
        .addr_hi (dec_hi),
        .s1      (d1),
        .s2      (d2),
        .s3      (d3),
        .miss    (miss)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                mode_d  = req_mode;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = miss;
                state_d = miss ? DONE : ADDR;
            end
            ADDR: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: if (ready) begin
                err_d   = 1'b0;
                state_d = DONE;
                rd_d    = mode_q == MODE_READ ? rdata : rd_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_en  = state_q == ADDR || state_q == ACCESS;
    assign s1      = sel_en && d1;
    assign s2      = sel_en && d2;
    assign s3      = sel_en && d3;
    assign valid   = state_q == ACCESS;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign err     = done && err_q;
    assign mode    = mode_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign rd_data = rd_q;

endmodule
